// File: rtl/fmul_pipe.sv
// MIX-style floating-point multiply: DIGIT-bit shift-and-add, one-byte normalize, round half-to-even.
// Optional build macro FMUL_SATURATE_EN clamps out-of-range results instead of wrapping the exponent.
module fmul_pipe #(
    parameter  int BYTE       = 6,
    parameter  int FRAC_BYTES = 4,
    parameter  int DIGIT      = 4,
    localparam int FB         = FRAC_BYTES * BYTE,
    localparam int W          = 1 + BYTE + FB
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] in1,
    input  logic [W-1:0] in2,
    output logic [W-1:0] out,
    output logic         busy,
    output logic         done,
    output logic         overflow,
    output logic         underflow
);

    localparam int N    = FB / DIGIT;
    localparam int EW   = BYTE + 2;
    localparam int CW   = $clog2(N + 2);
    localparam int BIAS = 1 << (BYTE - 1);
    localparam logic signed [EW-1:0] EXP_LIM = EW'(1 << BYTE);

    typedef enum logic [1:0] {IDLE, MUL, NORM} state_t;

    state_t                state_q;
    logic                  sign_q;
    logic signed [EW-1:0]  exp_q;
    logic [FB-1:0]         a_q, b_q;
    logic [2*FB-1:0]       acc_q;
    logic [CW-1:0]         cnt_q;
    logic                  zero_q;
    logic [W-1:0]          out_q;
    logic                  busy_q, done_q, ovf_q, unf_q;

    logic [FB+DIGIT-1:0]   pp;
    logic [2*FB-1:0]       acc_n;
    logic signed [EW-1:0]  exp_n, exp_f;
    logic                  rnd;
    logic [FB:0]           m_d, m_f;
    logic [W-1:0]          res_d;
    logic                  ovf_d, unf_d;

    assign pp = (FB + DIGIT)'(a_q[FB-1 -: DIGIT]) * (FB + DIGIT)'(b_q);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        acc_n = acc_q;
        exp_n = exp_q;
        if (acc_q[2*FB-1 -: BYTE] == '0) begin
            acc_n = acc_q << BYTE;
            exp_n = exp_q - EW'(1);
        end
        rnd   = acc_n[FB-1] & ((|acc_n[FB-2:0]) | acc_n[FB]);
        m_d   = {1'b0, acc_n[2*FB-1:FB]} + {{FB{1'b0}}, rnd};
        m_f   = m_d;
        exp_f = exp_n;
        if (m_d[FB]) begin
            m_f   = m_d >> BYTE;
            exp_f = exp_n + EW'(1);
        end
        ovf_d = (exp_f >= EXP_LIM);
        unf_d = exp_f[EW-1];
        res_d = {sign_q, exp_f[BYTE-1:0], m_f[FB-1:0]};
`ifdef FMUL_SATURATE_EN
        if (ovf_d) begin
            res_d = {sign_q, {(W-1){1'b1}}};
        end else if (unf_d) begin
            res_d = {sign_q, {(W-1){1'b0}}};
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments only; every register, including
    // the datapath, is cleared by reset so an abandoned operation leaves nothing behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            zero_q  <= 1'b0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sign_q  <= in1[W-1] ^ in2[W-1];
                        exp_q   <= EW'(in1[W-2 -: BYTE]) + EW'(in2[W-2 -: BYTE]) - EW'(BIAS);
                        a_q     <= in1[FB-1:0];
                        b_q     <= in2[FB-1:0];
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        ovf_q   <= 1'b0;
                        unf_q   <= 1'b0;
                        zero_q  <= (in1[FB-1:0] == '0) || (in2[FB-1:0] == '0);
                        state_q <= ((in1[FB-1:0] == '0) || (in2[FB-1:0] == '0)) ? NORM : MUL;
                    end
                end
                MUL: begin
                    if (cnt_q == CW'(N)) begin
                        state_q <= NORM;
                    end else begin
                        acc_q <= (acc_q << DIGIT) + (2*FB)'(pp);
                        a_q   <= a_q << DIGIT;
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                NORM: begin
                    // The zero path idles here so its latency matches the multiply path.
                    if (zero_q && (cnt_q != CW'(N + 1))) begin
                        cnt_q <= cnt_q + CW'(1);
                    end else begin
                        out_q   <= zero_q ? {sign_q, {(W-1){1'b0}}} : res_d;
                        ovf_q   <= zero_q ? 1'b0 : ovf_d;
                        unf_q   <= zero_q ? 1'b0 : unf_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out       = out_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule
